// File: rtl/fp_conv_pkg.sv
// Shared types and sizing helpers for the iterative fixed-to-float converter.
// Width-dependent constants are functions so every instance derives its own.
package fp_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int DEF_EXP_W  = 3;
    localparam int DEF_MANT_W = 4;

    function automatic int calc_data_w(input int exp_w, input int mant_w);
        return mant_w + (1 << exp_w);
    endfunction

    function automatic int calc_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    localparam int EMAX       = calc_emax(DEF_EXP_W);
    localparam int DEF_DATA_W = calc_data_w(DEF_EXP_W, DEF_MANT_W);

    // Most negative input and the positive value it clamps to.
    localparam logic [DEF_DATA_W-1:0] SAT_NEG_IN  = {1'b1, {(DEF_DATA_W-1){1'b0}}};
    localparam logic [DEF_DATA_W-1:0] SAT_POS_MAG = {1'b0, {(DEF_DATA_W-1){1'b1}}};

endpackage

// File: rtl/fp_abs_sat.sv
// Saturating two's-complement magnitude: the most negative code maps to the
// largest positive code so the result always fits in W-1 magnitude bits.
module fp_abs_sat #(
    parameter int W = 12
) (
    input  logic [W-1:0] d,
    output logic [W-1:0] mag
);

    // Negate negative inputs, clamping the one code that has no positive twin.
    always_comb begin
        mag = d;
        if (d == {1'b1, {(W-1){1'b0}}}) begin
            mag = {1'b0, {(W-1){1'b1}}};
        end else if (d[W-1]) begin
            mag = (~d) + {{(W-1){1'b0}}, 1'b1};
        end else begin
            mag = d;
        end
    end

endmodule

// File: rtl/fp_convert_iter.sv
// Iterative converter: one normalising shift per clock, optional round-to-nearest
// with exponent saturation, results returned over a valid/ready handshake.
module fp_convert_iter
    import fp_conv_pkg::*;
#(
    parameter  int EXP_W  = 3,
    parameter  int MANT_W = 4,
    localparam int DATA_W = calc_data_w(EXP_W, MANT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] D,
    input  logic              round_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              S,
    output logic [EXP_W-1:0]  E,
    output logic [MANT_W-1:0] F
);

    localparam logic [EXP_W-1:0] EMAX_V = EXP_W'(calc_emax(EXP_W));

    state_t              state_r;
    state_t              state_nx_s;
    logic [DATA_W-1:0]   mag_r;
    logic [DATA_W-1:0]   abs_s;
    logic [EXP_W-1:0]    exp_r;
    logic                rnd_r;
    logic                sign_r;
    logic                norm_done_s;
    logic [MANT_W-1:0]   f0_s;
    logic                guard_s;
    logic [MANT_W-1:0]   f_nx_s;
    logic [EXP_W-1:0]    e_nx_s;

    fp_abs_sat #(.W(DATA_W)) u_abs (
        .d   (D),
        .mag (abs_s)
    );

    assign norm_done_s = (exp_r == {EXP_W{1'b0}}) || mag_r[DATA_W-2];
    assign f0_s        = mag_r[DATA_W-2 -: MANT_W];
    assign guard_s     = mag_r[DATA_W-2-MANT_W];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    if (in_valid) state_nx_s = NORM;  else state_nx_s = IDLE;
            NORM:    if (norm_done_s) state_nx_s = ROUND; else state_nx_s = NORM;
            ROUND:   state_nx_s = OUT;
            OUT:     if (out_ready) state_nx_s = IDLE; else state_nx_s = OUT;
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (state_r == IDLE) begin
            in_ready = 1'b1;
        end else if (state_r == OUT) begin
            out_valid = 1'b1;
        end else begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    // Rounding: a carry out of an all-ones significand bumps the exponent,
    // and at the top exponent the result clamps to the largest value instead.
    always_comb begin
        f_nx_s = f0_s;
        e_nx_s = exp_r;
        if (!rnd_r || !guard_s) begin
            f_nx_s = f0_s;
            e_nx_s = exp_r;
        end else if (f0_s != {MANT_W{1'b1}}) begin
            f_nx_s = f0_s + {{(MANT_W-1){1'b0}}, 1'b1};
        end else if (exp_r < EMAX_V) begin
            f_nx_s = {1'b1, {(MANT_W-1){1'b0}}};
            e_nx_s = exp_r + {{(EXP_W-1){1'b0}}, 1'b1};
        end else begin
            f_nx_s = {MANT_W{1'b1}};
            e_nx_s = EMAX_V;
        end
    end

    // Datapath: capture on accept, shift while normalising, publish on ROUND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_r  <= {DATA_W{1'b0}};
            exp_r  <= {EXP_W{1'b0}};
            rnd_r  <= 1'b0;
            sign_r <= 1'b0;
            S      <= 1'b0;
            E      <= {EXP_W{1'b0}};
            F      <= {MANT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mag_r  <= abs_s;
                        exp_r  <= EMAX_V;
                        rnd_r  <= round_en;
                        sign_r <= D[DATA_W-1];
                    end
                end
                NORM: begin
                    if (!norm_done_s) begin
                        mag_r <= {mag_r[DATA_W-2:0], 1'b0};
                        exp_r <= exp_r - {{(EXP_W-1){1'b0}}, 1'b1};
                    end
                end
                ROUND: begin
                    S <= sign_r;
                    E <= e_nx_s;
                    F <= f_nx_s;
                end
                default: begin
                    mag_r <= mag_r;
                end
            endcase
        end
    end

endmodule
